// File: rtl/pixel_frame_streamer_pkg.sv
// Shared constants, state encoding and output beat layout for the canvas-to-network
// pixel streamer.
package pixel_frame_streamer_pkg;

    localparam int unsigned GRID_SIZE  = 28;
    localparam int unsigned NUM_PIXELS = GRID_SIZE * GRID_SIZE;
    localparam int unsigned ADDR_WIDTH = $clog2(NUM_PIXELS);
    localparam int unsigned DATA_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] ON_VALUE  = 8'd255;
    localparam logic [DATA_WIDTH-1:0] OFF_VALUE = 8'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DONE   = 2'b10
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] index;
        logic                  last;
    } pixel_beat_t;

endpackage

// File: rtl/pixel_frame_streamer_skid.sv
// Two-entry valid/ready output stage: an output register backed by one skid entry.
// free_slots_o already credits a handshake happening in the current cycle.
module stream_skid_buffer
    import pixel_frame_streamer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [ADDR_WIDTH-1:0] push_index_i,
    input  logic                  push_last_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_index_o,
    output logic                  out_last_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [1:0]            free_slots_o
);

    pixel_beat_t out_q, out_d, skid_q, skid_d, push_beat;
    logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic        pop;

    assign push_beat = '{data: push_data_i, index: push_index_i, last: push_last_i};
    assign pop       = out_valid_q && out_ready_i;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || pop) begin
            // The skid entry is older than the incoming beat, so it drains first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = push_i;
                if (push_i) skid_d = push_beat;
            end else begin
                out_valid_d = push_i;
                if (push_i) out_d = push_beat;
            end
        end else if (push_i) begin
            skid_d       = push_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (rst_i) begin
            // NOTE: payload registers are reset too, so out_data reads 0 right after reset.
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_data_o   = out_q.data;
    assign out_index_o  = out_q.index;
    assign out_last_o   = out_q.last;
    assign out_valid_o  = out_valid_q;
    assign free_slots_o = 2'd2 - ({1'b0, out_valid_q} + {1'b0, skid_valid_q}) + {1'b0, pop};

endmodule

// File: rtl/pixel_frame_streamer.sv
// Streams the 28x28 one-bit canvas in raster order as DATA_WIDTH activations over
// valid/ready, counting drawn pixels for the debug display.
module pixel_frame_streamer
    import pixel_frame_streamer_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_en,
    input  logic                  mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] pixel_count
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] pixel_count_q, pixel_count_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            free_slots;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] push_index;
    logic [DATA_WIDTH-1:0] push_data;

    assign handshake = out_valid && out_ready;
    // An in-flight read always belongs to the address just before the read pointer.
    assign push_index = rd_ptr_q - 1'b1;
    assign push_data  = mem_rd_data ? ON_VALUE : OFF_VALUE;

    stream_skid_buffer u_skid (
        .clk_i        (CLOCK_50),
        .rst_i        (reset),
        .push_i       (inflight_q),
        .push_data_i  (push_data),
        .push_index_i (push_index),
        .push_last_i  (push_index == ADDR_WIDTH'(NUM_PIXELS - 1)),
        .out_data_o   (out_data),
        .out_index_o  (out_index),
        .out_last_o   (out_last),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .free_slots_o (free_slots)
    );

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        pixel_count_d = pixel_count_q;
        inflight_d    = 1'b0;
        mem_rd_en     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = STREAM;
                    rd_ptr_d      = '0;
                    pixel_count_d = '0;
                end
            end
            STREAM: begin
                busy = 1'b1;
                // A new read needs a buffer slot beyond the one the in-flight read has claimed.
                if (rd_ptr_q < ADDR_WIDTH'(NUM_PIXELS) && free_slots > {1'b0, inflight_q}) begin
                    mem_rd_en  = 1'b1;
                    inflight_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                end
                if (handshake && out_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (handshake && out_data == ON_VALUE) pixel_count_d = pixel_count_q + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            pixel_count_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            pixel_count_q <= pixel_count_d;
            inflight_q    <= inflight_d;
        end
    end

    assign mem_rd_addr = mem_rd_en ? rd_ptr_q : '0;
    assign pixel_count = pixel_count_q;

endmodule

// File: doc/pixel_frame_streamer.md
Name: pixel_frame_streamer

Overview:
- Downstream stage of the 28x28 drawing canvas. It reads the 784-entry 1-bit pixel memory and streams it, raster order, to the neural-network input layer.
- Each bit is expanded to a DATA_WIDTH activation value and sent over a valid/ready handshake, with a last flag and a done pulse.
- It also counts set pixels, for HEX/LEDR debug display.

Parameters:
- GRID_SIZE, 28, canvas side length in cells.
- NUM_PIXELS, 784, GRID_SIZE*GRID_SIZE, frame length.
- ADDR_WIDTH, 10, width of pixel address/index (ceil log2 NUM_PIXELS).
- DATA_WIDTH, 8, width of emitted activation.
- ON_VALUE, 8'd255, activation emitted for a drawn (1) pixel.
- OFF_VALUE, 8'd0, activation emitted for a blank (0) pixel.

Ports:
- CLOCK_50 in 1: the block's single clock.
- reset in 1: synchronous, active-high reset.
- start in 1: one-cycle request to stream one frame. Sampled only in IDLE.
- busy out 1: high from the cycle after an accepted start until done.
- done out 1: one-cycle pulse after the final output handshake.
- mem_rd_addr out ADDR_WIDTH: pixel memory read address, index = y*GRID_SIZE + x.
- mem_rd_en out 1: read strobe. mem_rd_data is valid exactly 1 cycle after mem_rd_en.
- mem_rd_data in 1: pixel bit returned by memory.
- out_data out DATA_WIDTH: activation value.
- out_valid out 1: out_data/out_index/out_last are valid.
- out_ready in 1: consumer accepts. A handshake is out_valid && out_ready on the same edge.
- out_index out ADDR_WIDTH: pixel index of current out_data.
- out_last out 1: high with index NUM_PIXELS-1.
- pixel_count out ADDR_WIDTH: number of 1-pixels emitted in the current/last frame.

Behaviour:
- Reset values, applied at the first edge with reset=1:
  - State = IDLE.
  - busy, done, out_valid, out_last, mem_rd_en = 0.
  - mem_rd_addr, out_index, out_data, pixel_count = 0.
  - Internal read pointer, in-flight flag and skid entry cleared.
- Reset mid-stream aborts the frame. No done pulse. The consumer sees out_valid drop at that edge.
- States:
  - IDLE: start=1 -> STREAM. The read pointer and pixel_count clear and busy goes 1 the next cycle.
  - STREAM: issue reads and emit data. After the handshake with index NUM_PIXELS-1 -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Read issue:
  - In STREAM, mem_rd_en=1 at address rd_ptr only if rd_ptr < NUM_PIXELS.
  - In addition, occupancy must stay at or below 2 counting the output register, the skid entry and the in-flight read, taking into account a handshake occurring this cycle.
  - rd_ptr increments on each issued read. No read is ever issued at address NUM_PIXELS or above; there is no wrap-around.
- Returned data:
  - Returned bit maps to ON_VALUE or OFF_VALUE. It loads the output register if that register is empty or being drained this cycle; otherwise it goes to the skid entry.
  - Order is strictly preserved, so out_index increments by 1 per handshake starting at 0.
- Throughput and latency:
  - With out_ready held 1, throughput is 1 pixel/cycle.
  - First out_valid is 2 cycles after start: start edge -> first read issue -> data registered.
  - A full frame completes its last handshake at start+2+783 cycles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index and out_last are held stable. No data is lost or duplicated.
- pixel_count increments on each handshake whose data is ON_VALUE. Its maximum is 784, which fits ADDR_WIDTH, so it does not saturate. It holds its value after done until the next start.
- start is ignored while busy or in DONE.
- out_ready toggling every cycle is legal.
- The memory contents are not required to be stable during a frame; the block emits whatever it reads.

Decomposition:
- Shared package holds:
  - GRID_SIZE, NUM_PIXELS, ADDR_WIDTH, DATA_WIDTH.
  - ON_VALUE, OFF_VALUE.
  - State encoding: IDLE=2'b00, STREAM=2'b01, DONE=2'b10.
- One sub-module, stream_skid_buffer: a 2-entry valid/ready output stage holding {data, index, last}. It reports free-slot count to the read-issue logic.
- The top contains the FSM, read pointer, in-flight flag and pixel counter.

Test Plan:
- Blank memory, out_ready=1, start pulse:
  - 784 handshakes, all out_data=0, indices 0..783 contiguous.
  - out_last only at 783; done one cycle after; pixel_count=0.
- Memory with bits 0, 405 and 783 set, out_ready=1:
  - out_data=255 exactly at indices 0, 405 and 783; pixel_count=3.
  - First out_valid 2 cycles after start.
- Checkerboard memory, out_ready random 50%:
  - Sequence matches the reference model with no gaps, drops or duplicates.
  - out_data is stable during every stall; 392 ones are counted.
- out_ready=0 for 20 cycles after the first valid:
  - At most 2 reads are outstanding/buffered.
  - mem_rd_addr never exceeds 2; streaming resumes at index 0.
- Reset asserted at index 300:
  - Next edge: out_valid=0, busy=0, no done.
  - A new start restreams from index 0.
- A second start pulse mid-frame: ignored, and the frame continues unchanged.
- After done, a start pulse streams a fresh frame with pixel_count restarting at 0.
